// File: rtl/ws2811_source_arbiter.sv
// ws2811_source_arbiter: round-robin owner selection between NSRC colour
// sources feeding one ws2811 driver. Ownership only moves on a frame
// boundary (address wrapping to 0), with a minimum hold per owner and
// optional all-black frames between owners.
module ws2811_source_arbiter #(
   parameter int unsigned NSRC         = 4,
   parameter int unsigned NUM_LEDS     = 50,
   parameter int unsigned MIN_FRAMES   = 4,
   parameter int unsigned BLANK_FRAMES = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [7:0]           address,
   input  logic [NSRC-1:0]      req,
   input  logic [NSRC*24-1:0]   src_rgb,
   output logic [7:0]           red,
   output logic [7:0]           green,
   output logic [7:0]           blue,
   output logic [NSRC-1:0]      grant,
   output logic                 frame_start,
   output logic                 busy_blank
);

   localparam int unsigned OW = $clog2(NSRC);
   localparam int unsigned PW = OW + 1;

   localparam logic [0:0] ST_OWN   = 1'b0;
   localparam logic [0:0] ST_BLANK = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [OW-1:0]    owner_q, owner_d;
   logic [OW-1:0]    next_owner_q, next_owner_d;
   logic [7:0]       hold_cnt_q, hold_cnt_d;
   logic [3:0]       blank_cnt_q, blank_cnt_d;
   logic [7:0]       prev_addr_q;
   logic [NSRC-1:0]  grant_q, grant_d;
   logic             frame_start_q;
   logic             busy_blank_q, busy_blank_d;

   logic             boundary;
   logic             rr_found;
   logic [OW-1:0]    rr_idx;
   logic [PW-1:0]    probe;
   logic [OW-1:0]    cand;
   logic             hold_done;
   logic [OW-1:0]    sel_owner;
   logic             blank_out;
   logic [23:0]      sel_rgb;

   // A new frame starts when an in-range zero address follows a non-zero one.
   assign boundary = (address == 8'd0) && (prev_addr_q != 8'd0)
                     && ({1'b0, address} < 9'(NUM_LEDS));

   assign hold_done = ({1'b0, hold_cnt_q} + 9'd1) >= 9'(MIN_FRAMES);

   // Round-robin search for the first requester after the current owner;
   // the owner itself is probed last (k == NSRC wraps back onto it).
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = '0;
      probe    = '0;
      for (int unsigned k = 1; k <= NSRC; k++) begin
         probe = {1'b0, owner_q} + PW'(k);
         if (probe >= PW'(NSRC)) probe = probe - PW'(NSRC);
         if (!rr_found && req[probe[OW-1:0]]) begin
            rr_found = 1'b1;
            rr_idx   = probe[OW-1:0];
         end
      end
      // With nobody requesting, source 0 (default animation) takes over.
      cand = rr_found ? rr_idx : '0;
   end

   // Ownership/blanking decision, evaluated only on a boundary cycle.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      next_owner_d = next_owner_q;
      hold_cnt_d   = hold_cnt_q;
      blank_cnt_d  = blank_cnt_q;
      grant_d      = grant_q;
      busy_blank_d = busy_blank_q;
      if (boundary) begin
         case (state_q)
            ST_OWN: begin
               hold_cnt_d = (hold_cnt_q == 8'hFF) ? 8'hFF : hold_cnt_q + 8'd1;
               if (hold_done && (cand != owner_q)) begin
                  hold_cnt_d = '0;
                  if (BLANK_FRAMES != 0) begin
                     state_d      = ST_BLANK;
                     next_owner_d = cand;
                     blank_cnt_d  = 4'(BLANK_FRAMES);
                     grant_d      = '0;
                     busy_blank_d = 1'b1;
                  end else begin
                     owner_d = cand;
                     grant_d = NSRC'(1) << cand;
                  end
               end
            end
            default: begin
               blank_cnt_d = blank_cnt_q - 4'd1;
               if (blank_cnt_q == 4'd1) begin
                  state_d      = ST_OWN;
                  owner_d      = next_owner_q;
                  grant_d      = NSRC'(1) << next_owner_q;
                  hold_cnt_d   = '0;
                  busy_blank_d = 1'b0;
               end
            end
         endcase
      end
   end

   // Colour mux follows the next-state decision so pixel 0 of a new frame
   // already carries the new owner (or black); reset forces source 0.
   always_comb begin
      sel_owner = reset ? '0 : owner_d;
      blank_out = !reset && (state_d == ST_BLANK);
      sel_rgb   = '0;
      for (int unsigned i = 0; i < NSRC; i++) begin
         if (sel_owner == OW'(i)) sel_rgb = src_rgb[24*i +: 24];
      end
      if (blank_out) sel_rgb = '0;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_OWN;
         owner_q       <= '0;
         next_owner_q  <= '0;
         hold_cnt_q    <= '0;
         blank_cnt_q   <= '0;
         prev_addr_q   <= '0;
         grant_q       <= NSRC'(1);
         frame_start_q <= 1'b0;
         busy_blank_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         next_owner_q  <= next_owner_d;
         hold_cnt_q    <= hold_cnt_d;
         blank_cnt_q   <= blank_cnt_d;
         prev_addr_q   <= address;
         grant_q       <= grant_d;
         frame_start_q <= boundary;
         busy_blank_q  <= busy_blank_d;
      end
   end

   assign red         = sel_rgb[23:16];
   assign green       = sel_rgb[15:8];
   assign blue        = sel_rgb[7:0];
   assign grant       = grant_q;
   assign frame_start = frame_start_q;
   assign busy_blank  = busy_blank_q;

endmodule

// File: tb/tb_ws2811_source_arbiter.sv
// Directed bench for ws2811_source_arbiter: two instances share clock,
// reset, address and colour inputs; the second has no blank frames and
// a one-frame hold.
module tb_ws2811_source_arbiter;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    address = 8'd0;
   logic [3:0]    req = 4'd0;
   logic [3:0]    req_b = 4'd0;
   logic [95:0]   src_rgb;
   logic [7:0]    red, green, blue;
   logic [7:0]    red_b, green_b, blue_b;
   logic [3:0]    grant, grant_b;
   logic          frame_start, frame_start_b;
   logic          busy_blank, busy_blank_b;

   int unsigned   vectors = 0;
   int unsigned   miscompares = 0;
   logic          busy_b_seen = 1'b0;
   int unsigned   fs_count;

   logic [23:0]   src_tab [4];

   initial begin
      src_tab[0] = 24'h320000;
      src_tab[1] = 24'h010203;
      src_tab[2] = 24'h0A0B0C;
      src_tab[3] = 24'h112233;
   end
   assign src_rgb = {src_tab[3], src_tab[2], src_tab[1], src_tab[0]};

   always #5 clk = ~clk;

   ws2811_source_arbiter #(
      .NSRC(4), .NUM_LEDS(50), .MIN_FRAMES(4), .BLANK_FRAMES(1)
   ) dut (
      .clk(clk), .reset(reset), .address(address), .req(req),
      .src_rgb(src_rgb), .red(red), .green(green), .blue(blue),
      .grant(grant), .frame_start(frame_start), .busy_blank(busy_blank)
   );

   ws2811_source_arbiter #(
      .NSRC(4), .NUM_LEDS(50), .MIN_FRAMES(1), .BLANK_FRAMES(0)
   ) dut_b (
      .clk(clk), .reset(reset), .address(address), .req(req_b),
      .src_rgb(src_rgb), .red(red_b), .green(green_b), .blue(blue_b),
      .grant(grant_b), .frame_start(frame_start_b), .busy_blank(busy_blank_b)
   );

   always @(negedge clk) if (busy_blank_b) busy_b_seen = 1'b1;

   task automatic check_vec(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One pixel per clock: address steps 0..49 and wraps.
   task automatic advance(input int unsigned n);
      for (int unsigned s = 0; s < n; s++) begin
         @(posedge clk);
         #1;
         address = (address == 8'd49) ? 8'd0 : address + 8'd1;
         #1;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Test 1: reset state and one full sweep with source 0.
      reset = 1'b1;
      address = 8'd0;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check_vec("t1_rst_grant", 32'(grant), 32'h1);
      check_vec("t1_rst_busy", 32'(busy_blank), 32'h0);
      check_vec("t1_rst_fs", 32'(frame_start), 32'h0);
      check_vec("t1_rst_red", 32'(red), 32'h32);
      fs_count = 0;
      for (int unsigned s = 1; s <= 100; s++) begin
         advance(1);
         if (frame_start) fs_count++;
         check_vec("t1_red", 32'(red), 32'h32);
      end
      check_vec("t1_fs_count", fs_count, 32'd1);
      check_vec("t1_grant", 32'(grant), 32'h1);

      // Test 2: req[2] rises mid-frame; hold 4 frames, 1 blank frame.
      advance(25);
      req = 4'b0100;
      advance(25);                                 // step 150, 3rd boundary
      check_vec("t2_b3_rgb", {8'd0, red, green, blue}, 32'h320000);
      advance(1);
      check_vec("t2_b3_grant", 32'(grant), 32'h1);
      advance(49);                                 // step 200, 4th boundary
      check_vec("t2_blank_px0", {8'd0, red, green, blue}, 32'h0);
      check_vec("t2_grant_lag", 32'(grant), 32'h1);
      advance(1);
      check_vec("t2_blank_grant", 32'(grant), 32'h0);
      check_vec("t2_blank_busy", 32'(busy_blank), 32'h1);
      check_vec("t2_blank_fs", 32'(frame_start), 32'h1);
      advance(24);
      check_vec("t2_blank_mid", {8'd0, red, green, blue}, 32'h0);
      advance(25);                                 // step 250
      check_vec("t2_new_px0", {8'd0, red, green, blue}, 32'h0A0B0C);
      check_vec("t2_busy_still", 32'(busy_blank), 32'h1);
      advance(1);
      check_vec("t2_new_grant", 32'(grant), 32'h4);
      check_vec("t2_busy_drop", 32'(busy_blank), 32'h0);

      // Test 3: get to owner 1, then req=1110 rotates 2,3,1,2,3.
      req = 4'b0010;
      advance(249);                                // step 500
      check_vec("t3_to1_px0", {8'd0, red, green, blue}, 32'(src_tab[1]));
      advance(1);
      check_vec("t3_to1_grant", 32'(grant), 32'h2);
      req = 4'b1110;
      begin
         int unsigned order [5] = '{2, 3, 1, 2, 3};
         for (int unsigned j = 0; j < 5; j++) begin
            advance(199);
            check_vec("t3_blank_px0", {8'd0, red, green, blue}, 32'h0);
            advance(50);
            check_vec("t3_px0", {8'd0, red, green, blue}, 32'(src_tab[order[j]]));
            check_vec("t3_addr0", 32'(address), 32'h0);
            advance(1);
            check_vec("t3_grant", 32'(grant), 32'h1 << order[j]);
         end
      end

      // Test 4: owner 3 drops req mid-frame, falls back to 0 via blank.
      advance(24);
      req = 4'b0000;
      advance(126);                                // step 1901
      check_vec("t4_hold_kept", 32'(grant), 32'h8);
      check_vec("t4_hold_rgb", {8'd0, red, green, blue}, 32'(src_tab[3]));
      advance(49);                                 // step 1950
      check_vec("t4_blank_px0", {8'd0, red, green, blue}, 32'h0);
      advance(1);
      check_vec("t4_blank_grant", 32'(grant), 32'h0);
      check_vec("t4_blank_busy", 32'(busy_blank), 32'h1);
      advance(49);                                 // step 2000
      check_vec("t4_back0_px0", {8'd0, red, green, blue}, 32'h320000);
      advance(1);
      check_vec("t4_back0_grant", 32'(grant), 32'h1);

      // Test 5: no blank frames; switch lands directly on pixel 0.
      req_b = 4'b0010;
      advance(48);                                 // step 2049
      check_vec("t5_last_px", {8'd0, red_b, green_b, blue_b}, 32'h320000);
      advance(1);
      check_vec("t5_px0", {8'd0, red_b, green_b, blue_b}, 32'(src_tab[1]));
      check_vec("t5_grant_lag", 32'(grant_b), 32'h1);
      advance(1);
      check_vec("t5_grant", 32'(grant_b), 32'h2);
      check_vec("t5_busy_never", 32'(busy_b_seen), 32'h0);

      // Test 6: reset during BLANK at address 23.
      req = 4'b0100;
      advance(172);                                // step 2223, in blank
      check_vec("t6_pre_addr", 32'(address), 32'd23);
      check_vec("t6_pre_busy", 32'(busy_blank), 32'h1);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check_vec("t6_grant", 32'(grant), 32'h1);
      check_vec("t6_busy", 32'(busy_blank), 32'h0);
      check_vec("t6_rgb", {8'd0, red, green, blue}, 32'h320000);
      check_vec("t6_fs", 32'(frame_start), 32'h0);
      fs_count = 0;
      for (int unsigned s = 0; s < 27; s++) begin
         advance(1);
         if (frame_start) fs_count++;
      end
      check_vec("t6_no_fs", fs_count, 32'd0);
      check_vec("t6_wrap_addr", 32'(address), 32'h0);
      advance(1);
      check_vec("t6_fs_after_wrap", 32'(frame_start), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
